// File: rtl/fpu_op_arbiter.sv
// Shares one registered FPU among NUM_REQ requesters, granted round-robin.
// Latency: handshake edge to resp_valid is FPU_LAT+2 edges; one operation in flight at a time.
// Backpressure: result is held in RESP until resp_ready; no request is accepted until then.
module fpu_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int FPU_LAT = 1
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_opa,
  input  logic [NUM_REQ*32-1:0]  req_opb,
  input  logic [NUM_REQ*2-1:0]   req_mode,
  input  logic [NUM_REQ*5-1:0]   req_op_code,
  output logic [31:0]            fpu_opa,
  output logic [31:0]            fpu_opb,
  output logic [1:0]             fpu_mode,
  output logic [4:0]             fpu_op_code,
  input  logic [31:0]            fpu_out,
  input  logic [4:0]             fpu_flags,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_data,
  output logic [4:0]             resp_flags,
  output logic                   busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] opa;
    logic [31:0] opb;
    logic [1:0]  mode;
    logic [4:0]  op_code;
  } op_t;

  state_t             state, state_nxt;
  op_t                hold_q, sel_op;
  logic [ID_W-1:0]    last_grant, grant_id, gnt_q;
  logic               grant_vld;
  logic [CNT_W-1:0]   lat_cnt;
  logic [31:0]        resp_data_q;
  logic [4:0]         resp_flags_q;
  logic [2*NUM_REQ-1:0] dbl_vld;
  logic [NUM_REQ-1:0] rot_vld;

  // Rotate so bit k is requester (last_grant+1+k) mod NUM_REQ; lowest set bit wins.
  assign dbl_vld = {req_valid, req_valid};
  assign rot_vld = NUM_REQ'(dbl_vld >> (int'(last_grant) + 1));

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_vld[k]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'((int'(last_grant) + 1 + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_op.opa     = req_opa[32*i +: 32];
        sel_op.opb     = req_opb[32*i +: 32];
        sel_op.mode    = req_mode[2*i +: 2];
        sel_op.op_code = req_op_code[5*i +: 5];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = ISSUE;
          // gated by rst so the accept drops the instant reset asserts
          req_ready = rst ? (NUM_REQ'(1) << grant_id) : '0;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (lat_cnt == '0) state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      last_grant   <= ID_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      hold_q       <= '0;
      lat_cnt      <= '0;
      resp_data_q  <= '0;
      resp_flags_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            hold_q     <= sel_op;
            gnt_q      <= grant_id;
            last_grant <= grant_id;
          end
        end
        ISSUE: lat_cnt <= CNT_W'(FPU_LAT - 1);
        WAIT: begin
          if (lat_cnt == '0) begin
            resp_data_q  <= fpu_out;
            resp_flags_q <= fpu_flags;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fpu_opa     = hold_q.opa;
  assign fpu_opb     = hold_q.opb;
  assign fpu_mode    = hold_q.mode;
  assign fpu_op_code = hold_q.op_code;
  assign resp_valid  = (state == RESP);
  assign resp_id     = gnt_q;
  assign resp_data   = resp_data_q;
  assign resp_flags  = resp_flags_q;
  assign busy        = (state != IDLE);

  a_ready_onehot: assert property (@(posedge clk_in) disable iff (!rst) $onehot0(req_ready));
  a_resp_in_resp: assert property (@(posedge clk_in) disable iff (!rst) resp_valid |-> state == RESP);

endmodule

// File: tb/tb_fpu_op_arbiter.sv
// Bench for fpu_op_arbiter: random and directed requests, a mock FPU, and a
// queue-based scoreboard checked by a separate monitor at the falling edge.
module tb_fpu_op_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 5;

  logic                  clk_in = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_opa, req_opb;
  logic [NUM_REQ*2-1:0]  req_mode;
  logic [NUM_REQ*5-1:0]  req_op_code;
  logic [31:0]           fpu_opa, fpu_opb, fpu_out;
  logic [1:0]            fpu_mode;
  logic [4:0]            fpu_op_code, fpu_flags;
  logic                  resp_valid, resp_ready, busy;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic [4:0]            resp_flags;

  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];
  logic [1:0]  op_m [NUM_REQ];
  logic [4:0]  op_c [NUM_REQ];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int age = 31;
  bit done = 1'b0;

  fpu_op_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .FPU_LAT(LAT)) dut (
    .clk_in(clk_in), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_mode(req_mode), .req_op_code(req_op_code),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_mode(fpu_mode), .fpu_op_code(fpu_op_code),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_flags(resp_flags), .busy(busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always_comb begin
    req_opa = '0; req_opb = '0; req_mode = '0; req_op_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_opa[32*i +: 32]   = op_a[i];
      req_opb[32*i +: 32]   = op_b[i];
      req_mode[2*i +: 2]    = op_m[i];
      req_op_code[5*i +: 5] = op_c[i];
    end
  end

  // Mock FPU: {result, flags}. NaN in, canonical NaN out; 1.0+2.0 gives 3.0.
  function automatic logic [36:0] fpu_model(logic [31:0] a, logic [31:0] b,
                                            logic [1:0] m, logic [4:0] op);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {32'h7FC00000, 5'b10001};
    if (op == 5'd0 && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 5'b00000};
    return {a + b + {op, m, 25'd0}, a[4:0] ^ b[4:0]};
  endfunction

  // The result is only correct exactly LAT edges after the operands settle;
  // any other sampling time sees the inverted value.
  always @(posedge clk_in or negedge rst) begin
    if (!rst) age <= 31;
    else if (|(req_valid & req_ready)) age <= 0;
    else if (age < 31) age <= age + 1;
  end

  logic [36:0] fpu_good;
  assign fpu_good  = fpu_model(fpu_opa, fpu_opb, fpu_mode, fpu_op_code);
  assign fpu_out   = (age == LAT) ? fpu_good[36:5] : ~fpu_good[36:5];
  assign fpu_flags = (age == LAT) ? fpu_good[4:0]  : ~fpu_good[4:0];

  function automatic int rr_pick(logic [NUM_REQ-1:0] v, int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_checks();
    chk("rst_ctrl", {busy, resp_valid, req_ready, resp_flags, resp_id}, 0);
    chk("rst_data", {resp_data, fpu_opa}, 0);
    chk("rst_fpu", {fpu_opb, fpu_mode, fpu_op_code}, 0);
  endtask

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [4:0]      flags;
  } exp_t;

  // Monitor / scoreboard
  initial begin
    exp_t        sb[$];
    bit          outstanding = 1'b0;
    bit          resp_seen = 1'b0;
    int          last_g = NUM_REQ - 1;
    int          grant_cyc = 0;
    int          g;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [31:0] x_a = '0, x_b = '0;
    logic [1:0]  x_m = '0;
    logic [4:0]  x_c = '0;
    forever begin
      @(negedge clk_in or negedge rst);
      if (!rst) begin
        #1;
        reset_checks();
        sb.delete();
        outstanding = 1'b0;
        resp_seen = 1'b0;
        last_g = NUM_REQ - 1;
      end else begin
        g = rr_pick(req_valid, last_g);
        exp_rdy = (!outstanding && g >= 0) ? (NUM_REQ'(1) << g) : '0;
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, outstanding);
        if (outstanding) begin
          chk("fpu_opa_opb", {fpu_opa, fpu_opb}, {x_a, x_b});
          chk("fpu_mode_op", {fpu_mode, fpu_op_code}, {x_m, x_c});
          if (resp_valid) begin
            if (!resp_seen) chk("latency", cyc - grant_cyc, LAT + 2);
            resp_seen = 1'b1;
            chk("resp_id", resp_id, sb[0].id);
            chk("resp_data", resp_data, sb[0].data);
            chk("resp_flags", resp_flags, sb[0].flags);
            if (resp_ready) begin
              void'(sb.pop_front());
              outstanding = 1'b0;
            end
          end else if (resp_seen || cyc - grant_cyc >= LAT + 2) begin
            chk("resp_valid_due", resp_valid, 1);
            resp_seen = 1'b1;
          end
        end else begin
          chk("resp_valid_idle", resp_valid, 0);
          if (g >= 0) begin
            x_a = op_a[g]; x_b = op_b[g]; x_m = op_m[g]; x_c = op_c[g];
            sb.push_back({ID_W'(g), fpu_model(x_a, x_b, x_m, x_c)});
            outstanding = 1'b1;
            resp_seen = 1'b0;
            last_g = g;
            grant_cyc = cyc;
          end
        end
      end
      if (cyc > 30000) begin
        chk("watchdog", 1, 0);
        break;
      end
      if (done) begin
        chk("drain_empty", sb.size(), 0);
        break;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic new_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] m, input logic [4:0] c);
    op_a[i] = a; op_b[i] = b; op_m[i] = m; op_c[i] = c;
    req_valid[i] = 1'b1;
  endtask

  task automatic rand_op(input int i);
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'h7FC00000;
    new_op(i, a, $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
  endtask

  // One cycle: sample accepts before the edge, update requesters after it.
  task automatic tick(input bit rnd_en, input logic [NUM_REQ-1:0] refill);
    logic [NUM_REQ-1:0] acc;
    @(negedge clk_in);
    acc = req_valid & req_ready;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        req_valid[i] = 1'b0;
        if (refill[i]) rand_op(i);
      end else if (rnd_en && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        rand_op(i);
      end else if (rnd_en && req_valid[i] && $urandom_range(0, 31) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    if (rnd_en) resp_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (|req_valid); n++) tick(1'b0, '0);
    repeat (LAT + 4) tick(1'b0, '0);
  endtask

  initial begin
    req_valid = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_m[i] = '0; op_c[i] = '0;
    end
    repeat (3) @(posedge clk_in);
    #3 rst = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk_in);
    #1;

    // single ADD 1.0 + 2.0 from requester 2
    new_op(2, 32'h3F800000, 32'h40000000, 2'd0, 5'd0);
    drain();

    // all four continuously valid: order 0,1,2,3,0,...
    for (int i = 0; i < NUM_REQ; i++) rand_op(i);
    repeat (6 * (LAT + 3)) tick(1'b0, '1);
    drain();

    // backpressure with requester 1, requester 0 waiting behind it
    resp_ready = 1'b0;
    rand_op(1);
    for (int n = 0; n < 40 && req_valid[1]; n++) tick(1'b0, '0);
    rand_op(0);
    repeat (LAT + 2 + 10) tick(1'b0, '0);
    resp_ready = 1'b1;
    drain();

    // NaN flags passthrough
    new_op(3, 32'h7FC00000, 32'h3F800000, 2'd0, 5'd3);
    drain();

    // random traffic with random backpressure
    repeat (800) tick(1'b1, '0);
    resp_ready = 1'b1;
    drain();

    // reset while requester 1 is in WAIT; 0 and 2 pending
    rand_op(1);
    for (int n = 0; n < 40 && req_valid[1]; n++) tick(1'b0, '0);
    tick(1'b0, '0);
    tick(1'b0, '0);
    rand_op(2);
    rand_op(0);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk_in);
    #3 rst = 1'b1;
    drain();

    done = 1'b1;
  end

endmodule

// File: doc/fpu_op_arbiter.md
Name: fpu_op_arbiter

Overview:
- Shares one registered single-precision FPU among NUM_REQ requesters.
- Each requester presents an operation through a valid/ready request channel. The block grants requesters round-robin and holds the operands stable at the FPU for FPU_LAT cycles.
- It then captures the result and exception flags and returns them on a valid/ready response channel tagged with the requester index.
- It sits between the FPU and its clients (issue logic, DMA-driven math engines).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must satisfy 2^ID_W >= NUM_REQ.
- FPU_LAT, 1, clock edges from the operands being stable at the FPU to the result being valid (1..15).

Ports:
- clk_in  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_opa  input  NUM_REQ*32  operand A, requester i at bits [32i+31:32i].
- req_opb  input  NUM_REQ*32  operand B, same packing.
- req_mode  input  NUM_REQ*2  rounding mode, packed.
- req_op_code  input  NUM_REQ*5  operation code, packed.
- fpu_opa  output  32  to FPU opa_in.
- fpu_opb  output  32  to FPU opb_in.
- fpu_mode  output  2  to FPU mode_in.
- fpu_op_code  output  5  to FPU op_code.
- fpu_out  input  32  FPU result.
- fpu_flags  input  5  {nan_in, overflow, in_exact, zero, op_nan} from the FPU.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  ID_W  index of the granted requester.
- resp_data  output  32  captured result.
- resp_flags  output  5  captured flags, same order as fpu_flags.
- busy  output  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all registered outputs are 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - The in-flight operation is discarded and no response is produced.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, scanning from last_grant+1 with wrap-around modulo NUM_REQ.
  - req_ready[g]=1 combinationally, only in IDLE. All other req_ready bits are 0.
  - On the handshake edge: capture opa/opb/mode/op_code of g into holding registers, latch g, last_grant<=g, go to ISSUE.
- ISSUE:
  - The fpu_* outputs drive the holding registers.
  - Load lat_cnt <= FPU_LAT-1, go to WAIT.
- WAIT:
  - fpu_* outputs remain stable.
  - If lat_cnt==0: capture fpu_out into resp_data and fpu_flags into resp_flags, go to RESP. Otherwise decrement lat_cnt.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_flags are held stable.
  - On resp_valid & resp_ready, go to IDLE. Otherwise remain in RESP (backpressure).
  - No new request is accepted while in RESP.
- fpu_* outputs hold their last values after the operation; they are not cleared until reset.
- Latency: request handshake edge to resp_valid high is FPU_LAT+2 edges.
  - Minimum issue interval is FPU_LAT+3 cycles when resp_ready is held high.
- Requester rules:
  - req_valid must stay high, with stable operands, until req_ready is seen.
  - A requester dropping req_valid before its grant simply loses that arbitration.
- Simultaneous valids are resolved strictly by the round-robin rule.
  - A requester granted last has lowest priority next time, so no requester starves.
- Assertions: req_ready is at most one-hot. resp_valid=1 implies state RESP.

Test Plan:
- Single op, NUM_REQ=4, FPU_LAT=1: req 2 presents opa=0x3F800000 (1.0), opb=0x40000000 (2.0), op ADD; FPU model returns 0x40400000 (3.0) -> req_ready[2] high one cycle, resp_valid 3 edges after the handshake, resp_id=2, resp_data=0x40400000, resp_flags=0.
- All four requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0; each response id matches and responses are spaced 4 cycles apart.
- Backpressure: resp_ready=0 for 10 cycles with req 1 pending -> resp_valid and resp_data held for all 10 cycles, req_ready stays 0, busy=1; transfer completes on the cycle resp_ready rises.
- FPU_LAT=5: fpu_opa and fpu_op_code stay constant from ISSUE through WAIT; the result is sampled exactly 5 edges after ISSUE, checked against a model changing fpu_out on every other edge.
- Flags passthrough: model drives fpu_flags=5'b10001 (nan_in, op_nan) with fpu_out=0x7FC00000 -> resp_flags=5'b10001, resp_data=0x7FC00000.
- Reset mid-WAIT: assert rst low asynchronously between edges -> busy, resp_valid and req_ready go 0 immediately. After release, the next grant goes to requester 0 and no stale response appears.
